seg7_scan_ctrl: RTL

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_scan_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller.
// Scans DIGITS digits as BLANK (all dark) then SHOW (one digit lit) slots.
// The display reads an active register set. A load writes a pending set,
// which becomes active at frame wrap, or at once while idle.
module seg7_scan_ctrl #(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 16,
  parameter int DIGITS    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic        lz_en,
  output logic        ready,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  dig_low,
  output logic        frame_done
);

  localparam int CMAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
  localparam int CW   = $clog2(CMAX);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [2:0]    IDX_LAST   = 3'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0][3:0] act_nib_q, act_nib_d, pend_nib_q, pend_nib_d;
  logic [7:0]      act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic            pend_vld_q, pend_vld_d;
  logic            ready_q, ready_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [7:0]      dig_low_q, dig_low_d;
  logic            frame_done_q, frame_done_d;
  logic            wrap, accept, zero_above;
  logic [7:0]      supp;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0: hex2seg = 7'h7E;  4'h1: hex2seg = 7'h30;
      4'h2: hex2seg = 7'h6D;  4'h3: hex2seg = 7'h79;
      4'h4: hex2seg = 7'h33;  4'h5: hex2seg = 7'h5B;
      4'h6: hex2seg = 7'h5F;  4'h7: hex2seg = 7'h70;
      4'h8: hex2seg = 7'h7F;  4'h9: hex2seg = 7'h7B;
      4'hA: hex2seg = 7'h77;  4'hB: hex2seg = 7'h1F;
      4'hC: hex2seg = 7'h4E;  4'hD: hex2seg = 7'h3D;
      4'hE: hex2seg = 7'h4F;  default: hex2seg = 7'h47;
    endcase
  endfunction

  // State, counters, register sets and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      act_nib_q    <= '0;
      act_dp_q     <= '0;
      pend_nib_q   <= '0;
      pend_dp_q    <= '0;
      pend_vld_q   <= 1'b0;
      ready_q      <= 1'b1;
      seg_q        <= '0;
      dp_q         <= 1'b0;
      dig_low_q    <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_nib_q    <= act_nib_d;
      act_dp_q     <= act_dp_d;
      pend_nib_q   <= pend_nib_d;
      pend_dp_q    <= pend_dp_d;
      pend_vld_q   <= pend_vld_d;
      ready_q      <= ready_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      dig_low_q    <= dig_low_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state: slot timing, digit index, wrap detection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wrap    = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = '0;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Pending/active register sets; a load landing on the wrap edge bypasses pending
  always_comb begin
    act_nib_d  = act_nib_q;
    act_dp_d   = act_dp_q;
    pend_nib_d = pend_nib_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    accept     = load && ready_q;
    if (accept) begin
      if (wrap) begin
        act_nib_d = data_in;
        act_dp_d  = dp_in;
      end else begin
        pend_nib_d = data_in;
        pend_dp_d  = dp_in;
        pend_vld_d = 1'b1;
      end
    end
    if (pend_vld_q && (wrap || state_q == IDLE)) begin
      act_nib_d  = pend_nib_q;
      act_dp_d   = pend_dp_q;
      pend_vld_d = 1'b0;
    end
    ready_d = ~pend_vld_d;
  end

  // Output decode from next state so registered outputs line up with state_q
  always_comb begin
    zero_above   = 1'b1;
    supp         = '0;
    seg_d        = '0;
    dp_d         = 1'b0;
    dig_low_d    = 8'hFF;
    frame_done_d = wrap;
    for (int k = 7; k >= 0; k--) begin
      if (k < DIGITS) begin
        zero_above = zero_above && (act_nib_d[k] == 4'h0) && !act_dp_d[k];
        supp[k]    = (k > 0) && lz_en && zero_above;
      end
    end
    if (state_d == SHOW) begin
      dig_low_d[idx_d] = 1'b0;
      dp_d             = act_dp_d[idx_d];
      seg_d            = supp[idx_d] ? 7'h00 : hex2seg(act_nib_d[idx_d]);
    end
  end

  assign ready      = ready_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign dig_low    = dig_low_q;
  assign frame_done = frame_done_q;

endmodule
